// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the generic pipeline-stage register.
package pipe_pkg;

    // Holding state of the stage: nothing, one beat in the main slot, or both slots full
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // Number of beats held in a given state
    function automatic logic [1:0] occOf(input pipe_state_t s);
        case (s)
            FULL:    return OCC_ONE;
            SKID:    return OCC_TWO;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready beat channel carrying a payload and a control field.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 2
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input ready);
    modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg_slot.sv
// One beat register: valid, payload and control. Clearing drops valid and
// zeroes control but keeps the payload so the data bus does not toggle.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [CTRL_W-1:0] ctrl_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;

    // Next slot contents: clear wins over load so a kill can never leave control bits set
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        if (clear_i) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
            ctrl_d  = ctrl_i;
        end
    end

    // Slot register with synchronous reset to an all-zero bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ctrl_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign ctrl_o  = ctrl_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register with optional two-entry skid buffer and flush.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 2,
    parameter int SKID   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    pipe_stage_reg_if.slave   in_if,
    pipe_stage_reg_if.master  out_if,
    output logic [1:0]        occupancy_o
);

    pipe_state_t       state_q, state_d;
    logic [1:0]        occ_q;
    logic              inReady, accept;
    logic              mLoad, mClear, mFromS, sLoad, sClear;
    logic              mValid, sValid;
    logic [DATA_W-1:0] mData, sData, mDataIn;
    logic [CTRL_W-1:0] mCtrl, sCtrl, mCtrlIn;

    // Upstream ready: registered-only with a skid slot, pass-through otherwise; low during reset
    always_comb begin
        inReady = 1'b0;
        if (!rst) begin
            if (SKID != 0) inReady = (state_q != pipe_pkg::SKID);
            else           inReady = !mValid || out_if.ready;
        end
    end

    assign accept = in_if.valid && inReady;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            occ_q   <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
            occ_q   <= occOf(state_d);
        end
    end

    // Next-state: flush empties the stage regardless of any handshake
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept) state_d = FULL;
                FULL: begin
                    if (accept && !out_if.ready && (SKID != 0)) state_d = pipe_pkg::SKID;
                    else if (!accept && out_if.ready)           state_d = EMPTY;
                end
                pipe_pkg::SKID: if (out_if.ready) state_d = FULL;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Slot controls: the skid beat always moves into the main slot before new beats land there
    always_comb begin
        mLoad  = 1'b0;
        mClear = 1'b0;
        mFromS = 1'b0;
        sLoad  = 1'b0;
        sClear = 1'b0;
        if (flush_i) begin
            mClear = 1'b1;
            sClear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: mLoad = accept;
                FULL: begin
                    if (accept && out_if.ready) mLoad  = 1'b1;
                    else if (accept)            sLoad  = 1'b1;
                    else if (out_if.ready)      mClear = 1'b1;
                end
                pipe_pkg::SKID: begin
                    if (out_if.ready) begin
                        mLoad  = sValid;
                        mFromS = 1'b1;
                        sClear = 1'b1;
                    end
                end
                default: begin
                    mClear = 1'b1;
                    sClear = 1'b1;
                end
            endcase
        end
    end

    assign mDataIn = mFromS ? sData : in_if.data;
    assign mCtrlIn = mFromS ? sCtrl : in_if.ctrl;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk     (clk),
        .rst     (rst),
        .load_i  (mLoad),
        .clear_i (mClear),
        .data_i  (mDataIn),
        .ctrl_i  (mCtrlIn),
        .valid_o (mValid),
        .data_o  (mData),
        .ctrl_o  (mCtrl)
    );

    generate
        if (SKID != 0) begin : gSkid
            pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk     (clk),
                .rst     (rst),
                .load_i  (sLoad),
                .clear_i (sClear),
                .data_i  (in_if.data),
                .ctrl_i  (in_if.ctrl),
                .valid_o (sValid),
                .data_o  (sData),
                .ctrl_o  (sCtrl)
            );
        end else begin : gNoSkid
            assign sValid = 1'b0;
            assign sData  = '0;
            assign sCtrl  = '0;
        end
    endgenerate

    assign in_if.ready  = inReady;
    assign out_if.valid = mValid;
    assign out_if.data  = mData;
    assign out_if.ctrl  = mCtrl;
    assign occupancy_o  = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomised checks of the stage register, with and without skid slot.
module tb_pipe_stage_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush1, flush0;
    logic [1:0] occ1, occ0;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [31:0] sb[$];
    logic        pending = 1'b0;
    logic [31:0] nextVal = 32'h100;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(2)) u_in ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(2)) u_out ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(2)) u0_in ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(2)) u0_out ();

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .SKID(1)) dut (
        .clk(clk), .rst(rst), .flush_i(flush1),
        .in_if(u_in), .out_if(u_out), .occupancy_o(occ1)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(2), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush0),
        .in_if(u0_in), .out_if(u0_out), .occupancy_o(occ0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One random-handshake cycle on the skid DUT, checked against a FIFO model
    task automatic applyStimulus(input logic wantValid, input logic outReady);
        logic acc;
        if (!pending) begin
            u_in.valid = wantValid;
            if (wantValid) begin
                u_in.data = nextVal;
                nextVal   = nextVal + 32'd1;
            end
        end
        u_out.ready = outReady;
        #1;
        if (!u_out.valid) checkOutput("bubbleCtrl", 32'(u_out.ctrl), 32'd0);
        else              checkOutput("validCtrl", 32'(u_out.ctrl), 32'd3);
        checkOutput("rndOcc", 32'(occ1), 32'(sb.size()));
        if (u_out.valid && u_out.ready) begin
            if (sb.size() == 0) checkOutput("rndSpurious", 32'd1, 32'd0);
            else begin
                checkOutput("rndOrder", u_out.data, sb[0]);
                void'(sb.pop_front());
            end
        end
        acc = u_in.valid && u_in.ready;
        if (acc) sb.push_back(u_in.data);
        pending = u_in.valid && !u_in.ready;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        flush1 = 1'b0; flush0 = 1'b0;
        u_in.valid = 1'b1; u_in.data = 32'hDEADBEEF; u_in.ctrl = 2'b11; u_out.ready = 1'b0;
        u0_in.valid = 1'b0; u0_in.data = '0; u0_in.ctrl = 2'b11; u0_out.ready = 1'b1;

        // Reset held for three cycles with a beat offered
        tick(); tick(); tick();
        checkOutput("rstOutValid", 32'(u_out.valid), 32'd0);
        checkOutput("rstOutData", u_out.data, 32'd0);
        checkOutput("rstOutCtrl", 32'(u_out.ctrl), 32'd0);
        checkOutput("rstInReady", 32'(u_in.ready), 32'd0);
        checkOutput("rstOcc", 32'(occ1), 32'd0);
        checkOutput("rstInReady0", 32'(u0_in.ready), 32'd0);
        rst = 1'b0;
        u_in.valid = 1'b0;
        #1;
        checkOutput("relInReady", 32'(u_in.ready), 32'd1);
        checkOutput("relInReady0", 32'(u0_in.ready), 32'd1);

        // Streaming 1..8 with the downstream always ready
        u_out.ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            u_in.valid = 1'b1;
            u_in.data  = 32'(i);
            tick();
            checkOutput("strValid", 32'(u_out.valid), 32'd1);
            checkOutput("strData", u_out.data, 32'(i));
            checkOutput("strCtrl", 32'(u_out.ctrl), 32'd3);
            checkOutput("strOcc", 32'(occ1), 32'd1);
        end
        u_in.valid = 1'b0;
        tick();
        checkOutput("strDrainValid", 32'(u_out.valid), 32'd0);
        checkOutput("strDrainCtrl", 32'(u_out.ctrl), 32'd0);
        checkOutput("strDrainOcc", 32'(occ1), 32'd0);

        // Backpressure: A and B held, C waits upstream
        u_out.ready = 1'b0;
        u_in.valid = 1'b1; u_in.data = 32'hA;
        tick();
        checkOutput("bpOccA", 32'(occ1), 32'd1);
        u_in.data = 32'hB;
        tick();
        u_in.data = 32'hC;
        #1;
        checkOutput("bpOccAB", 32'(occ1), 32'd2);
        checkOutput("bpInReady", 32'(u_in.ready), 32'd0);
        tick();
        checkOutput("bpHoldData", u_out.data, 32'hA);
        checkOutput("bpHoldOcc", 32'(occ1), 32'd2);
        checkOutput("bpHoldReady", 32'(u_in.ready), 32'd0);
        u_out.ready = 1'b1;
        tick();
        checkOutput("bpOutB", u_out.data, 32'hB);
        checkOutput("bpOccB", 32'(occ1), 32'd1);
        checkOutput("bpReadyB", 32'(u_in.ready), 32'd1);
        tick();
        checkOutput("bpOutC", u_out.data, 32'hC);
        u_in.valid = 1'b0;
        tick();
        checkOutput("bpEmptyOcc", 32'(occ1), 32'd0);
        checkOutput("bpEmptyValid", 32'(u_out.valid), 32'd0);

        // Flush while both slots are full, with a beat offered
        u_out.ready = 1'b0;
        u_in.valid = 1'b1; u_in.data = 32'h11;
        tick();
        u_in.data = 32'h22;
        tick();
        checkOutput("flOccBefore", 32'(occ1), 32'd2);
        flush1 = 1'b1; u_in.data = 32'hF;
        tick();
        flush1 = 1'b0; u_in.valid = 1'b0;
        checkOutput("flValid", 32'(u_out.valid), 32'd0);
        checkOutput("flCtrl", 32'(u_out.ctrl), 32'd0);
        checkOutput("flOcc", 32'(occ1), 32'd0);
        u_out.ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("flNoGhost", 32'(u_out.valid), 32'd0);
        end

        // Flush in FULL discards a beat handshaken in the same cycle
        u_out.ready = 1'b0;
        u_in.valid = 1'b1; u_in.data = 32'h33;
        tick();
        u_in.data = 32'h44; flush1 = 1'b1;
        #1;
        checkOutput("fl2InReady", 32'(u_in.ready), 32'd1);
        tick();
        flush1 = 1'b0; u_in.valid = 1'b0;
        checkOutput("fl2Valid", 32'(u_out.valid), 32'd0);
        checkOutput("fl2Occ", 32'(occ1), 32'd0);
        u_out.ready = 1'b1;
        tick();
        checkOutput("fl2NoGhost", 32'(u_out.valid), 32'd0);

        // Random handshakes against a FIFO scoreboard, then drain
        for (int i = 0; i < 1000; i++)
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int k = 0; k < 20 && (sb.size() != 0 || pending); k++)
            applyStimulus(1'b0, 1'b1);
        u_in.valid = 1'b0;
        checkOutput("rndDrained", 32'(sb.size()), 32'd0);
        tick();
        checkOutput("rndFinalOcc", 32'(occ1), 32'd0);

        // Single-slot variant: combinational ready and pass-through
        u0_in.valid = 1'b1; u0_in.data = 32'h55; u0_out.ready = 1'b0;
        tick();
        checkOutput("s0Valid", 32'(u0_out.valid), 32'd1);
        checkOutput("s0ReadyLow", 32'(u0_in.ready), 32'd0);
        tick();
        checkOutput("s0Hold", u0_out.data, 32'h55);
        checkOutput("s0OccHold", 32'(occ0), 32'd1);
        u0_out.ready = 1'b1;
        #1;
        checkOutput("s0ReadyComb", 32'(u0_in.ready), 32'd1);
        for (int v = 32'h61; v <= 32'h64; v++) begin
            u0_in.data = 32'(v);
            tick();
            checkOutput("s0Pass", u0_out.data, 32'(v));
            checkOutput("s0Occ", 32'(occ0), 32'd1);
        end
        u0_in.valid = 1'b0;
        tick();
        checkOutput("s0EmptyValid", 32'(u0_out.valid), 32'd0);
        checkOutput("s0EmptyCtrl", 32'(u0_out.ctrl), 32'd0);
        checkOutput("s0EmptyOcc", 32'(occ0), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic parametrised pipeline-stage register that replaces the fixed, width-specific inter-stage registers (IF/ID, ID/EX, EX/M, M/WB).
- Carries a data payload and a separate control field across a valid/ready handshake.
- Optional 2-entry skid buffer gives full throughput with registered backpressure.
- Synchronous flush inserts bubbles whose control bits are guaranteed zero (no spurious RegWrite/MemWrite).

Parameters:
- DATA_W, 32: payload width (ALU result, read data, register index, etc. concatenated).
- CTRL_W, 2: control-field width; forced to zero in any bubble.
- SKID, 1: 1 = two-entry skid buffer; 0 = single register with combinational ready.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream payload.
- in_ctrl  in  CTRL_W  upstream control bits.
- flush  in  1  synchronous kill of all held beats.
- out_valid  out  1  downstream beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_W  payload to next stage.
- out_ctrl  out  CTRL_W  control to next stage; zero whenever out_valid=0.
- occupancy  out  2  number of beats held (0..2).

Behaviour:
- Handshake: a beat transfers on a clock edge where valid && ready. The upstream holds in_data/in_ctrl stable while in_valid && !in_ready.
- Reset, when rst=1 at the edge:
  - out_valid=0, out_data=0, out_ctrl=0, occupancy=0, state EMPTY.
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after release.
  - rst overrides flush and all handshakes.
- SKID=1 state machine, with main slot M driving the outputs and skid slot S:
  - EMPTY: in_ready=1. Accept → FULL (M loaded).
  - FULL: in_ready=1.
    - Accept with out_ready → FULL (M reloaded).
    - Accept without out_ready → SKID (beat goes to S).
    - No accept with out_ready → EMPTY.
    - Otherwise hold.
  - SKID: in_ready=0.
    - out_ready → FULL (S moves to M).
    - Otherwise hold.
  - in_ready is a function of the state register only; there is no combinational path from out_ready.
  - Latency: 1 cycle from accept to out_valid. Sustained throughput is 1 beat/cycle.
  - Ordering is strictly FIFO: the S beat never overtakes the M beat.
- SKID=0:
  - in_ready = !out_valid || out_ready (combinational).
  - Single slot; occupancy is never 2.
- Flush at an edge (rst=0):
  - All slots are invalidated and out_ctrl is zeroed next cycle; state → EMPTY; occupancy → 0.
  - A beat handshaken in the flush cycle is discarded.
  - A downstream transfer in the flush cycle still counts as completed.
  - out_data is don't-care after flush; hold its previous value to save power.
- Bubble rule: out_ctrl == 0 whenever out_valid == 0, in all states and after reset or flush.
- Width rules: no arithmetic; data and control pass bit-exact.
- occupancy = 0/1/2 for EMPTY/FULL/SKID. It is registered and consistent with out_valid (out_valid = occupancy != 0).

Decomposition:
- Shared package pipe_pkg holds:
  - State enum pipe_state_t {EMPTY, FULL, SKID} (2 bits).
  - Occupancy constants OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2.
- Sub-module pipe_slot: one valid+data+ctrl register with load/clear inputs and ctrl-zeroing on clear. It is instantiated twice for SKID=1 and once for SKID=0.
- The top level holds the state machine and the in_ready logic.

Test Plan:
- Reset: hold rst=1 3 cycles with in_valid=1, in_data=0xDEADBEEF → out_valid=0, out_data=0, out_ctrl=0, in_ready=0; first cycle after release in_ready=1.
- Streaming: SKID=1, out_ready=1, 8 consecutive beats 0x1..0x8, ctrl=2'b11 → out_data shows 0x1..0x8 on 8 consecutive cycles starting 1 cycle after the first accept, no gaps.
- Backpressure: out_ready=0 while sending 0xA, 0xB, 0xC → 0xA and 0xB accepted, in_ready=0 with occupancy=2, 0xC held upstream. Release out_ready → output order 0xA, 0xB, 0xC; occupancy returns to 0.
- Flush in SKID: occupancy=2, assert flush with a simultaneous in_valid beat 0xF → next cycle out_valid=0, out_ctrl=0, occupancy=0; 0xF never appears at the output.
- Bubble control: random in_valid/out_ready for 1000 cycles, ctrl=2'b11 → assert out_ctrl==0 every cycle out_valid==0; scoreboard confirms an in-order, lossless stream.
- SKID=0 variant: out_ready=0 with out_valid=1 → in_ready=0 in the same cycle. out_ready=1 with in_valid=1 → pass-through at 1 beat/cycle; occupancy never exceeds 1.
